// File: rtl/mdio_controller.sv
// MDIO station-management initiator: serializes a 32-bit management frame at CLK/2,
// optionally preceded by a preamble, and captures the 16-bit reply on read frames.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for MDIO_START, MDC held low
// PREAMBLE | driving PREAMBLE_LEN '1' bits with the line enabled
// SHIFT    | driving / receiving the 32 frame bits
// DONE     | one-cycle completion pulse; accepts a new start like IDLE
module mdio_controller #(
    parameter int PREAMBLE_LEN = 0
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        MDIO_START,
    input  logic [31:0] T_DATA,
    input  logic        MDIO_IN,
    output logic        MDC,
    output logic        MDIO_OUT,
    output logic        MDIO_OE,
    output logic [15:0] RD_DATA,
    output logic        MDIO_DONE,
    output logic        BUSY
);

    typedef enum logic [1:0] {S_IDLE, S_PREAMBLE, S_SHIFT, S_DONE} state_t;

    localparam logic [6:0] TOTAL_BITS = 7'(PREAMBLE_LEN + 32);

    state_t      state_q, state_d;
    logic        phase_q, phase_d;
    logic [6:0]  cnt_q, cnt_d;
    logic [31:0] tx_q, tx_d;
    logic [15:0] rx_q, rx_d;
    logic        is_rd_q, is_rd_d;
    logic        mdc_d, out_d, oe_d, done_d, busy_d;
    logic [15:0] rd_data_d;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q   <= S_IDLE;
            phase_q   <= 1'b0;
            cnt_q     <= '0;
            tx_q      <= '0;
            rx_q      <= '0;
            is_rd_q   <= 1'b0;
            MDC       <= 1'b0;
            MDIO_OUT  <= 1'b0;
            MDIO_OE   <= 1'b0;
            MDIO_DONE <= 1'b0;
            BUSY      <= 1'b0;
            RD_DATA   <= '0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            cnt_q     <= cnt_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            is_rd_q   <= is_rd_d;
            MDC       <= mdc_d;
            MDIO_OUT  <= out_d;
            MDIO_OE   <= oe_d;
            MDIO_DONE <= done_d;
            BUSY      <= busy_d;
            RD_DATA   <= rd_data_d;
        end
    end

    // cnt_q counts bits still to be driven; frame bit k is driven while cnt_q == 32-k.
    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        cnt_d     = cnt_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        is_rd_d   = is_rd_q;
        mdc_d     = MDC;
        out_d     = MDIO_OUT;
        oe_d      = MDIO_OE;
        done_d    = 1'b0;
        busy_d    = BUSY;
        rd_data_d = RD_DATA;

        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                mdc_d   = 1'b0;
                out_d   = 1'b0;
                oe_d    = 1'b0;
                busy_d  = 1'b0;
                if (MDIO_START) begin
                    tx_d    = T_DATA;
                    rx_d    = '0;
                    is_rd_d = (T_DATA[29:28] == 2'b10);
                    cnt_d   = TOTAL_BITS;
                    phase_d = 1'b0;
                    busy_d  = 1'b1;
                    state_d = (PREAMBLE_LEN > 0) ? S_PREAMBLE : S_SHIFT;
                end
            end

            S_PREAMBLE, S_SHIFT: begin
                if (!phase_q) begin
                    mdc_d = 1'b0;
                    // MDC falling edge closes the previous bit; reply bits are frame bits 16..31.
                    if (cnt_q <= 7'd15)
                        rx_d = {rx_q[14:0], MDIO_IN};
                    if (cnt_q == 7'd0) begin
                        state_d = S_DONE;
                        out_d   = 1'b0;
                        oe_d    = 1'b0;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        if (is_rd_q)
                            rd_data_d = {rx_q[14:0], MDIO_IN};
                    end else begin
                        cnt_d   = cnt_q - 7'd1;
                        phase_d = 1'b1;
                        state_d = ((cnt_q - 7'd1) > 7'd32) ? S_PREAMBLE : S_SHIFT;
                        if (cnt_q > 7'd32) begin
                            out_d = 1'b1;
                            oe_d  = 1'b1;
                        end else if (is_rd_q && cnt_q <= 7'd18) begin
                            out_d = 1'b0;
                            oe_d  = 1'b0;
                        end else begin
                            out_d = tx_q[31];
                            oe_d  = 1'b1;
                            tx_d  = {tx_q[30:0], 1'b0};
                        end
                    end
                end else begin
                    mdc_d   = 1'b1;
                    phase_d = 1'b0;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_mdio_controller.sv
// Directed bench for mdio_controller: write, read, back-to-back, reset abort,
// non-read opcode and preamble timing, with hand-computed expectations.
module tb_mdio_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, start4;
    logic [31:0] tdata, tdata4;
    logic        mdio_in, mdio_in4;
    logic        mdc, mdio_out, mdio_oe, mdio_done, busy;
    logic        mdc4, mdio_out4, mdio_oe4, mdio_done4, busy4;
    logic [15:0] rd_data, rd_data4;

    int total = 0;
    int bad   = 0;

    // capture results
    logic [31:0] bits_seen, oe_seen;
    int          mdc_rises, done_at, done_cnt;
    logic        busy_e0, busy_at_done;
    logic [15:0] rd_at_done;

    always #5 clk = ~clk;

    mdio_controller #(.PREAMBLE_LEN(0)) dut (
        .CLK(clk), .RESET(reset), .MDIO_START(start), .T_DATA(tdata), .MDIO_IN(mdio_in),
        .MDC(mdc), .MDIO_OUT(mdio_out), .MDIO_OE(mdio_oe), .RD_DATA(rd_data),
        .MDIO_DONE(mdio_done), .BUSY(busy)
    );

    mdio_controller #(.PREAMBLE_LEN(4)) dut4 (
        .CLK(clk), .RESET(reset), .MDIO_START(start4), .T_DATA(tdata4), .MDIO_IN(mdio_in4),
        .MDC(mdc4), .MDIO_OUT(mdio_out4), .MDIO_OE(mdio_oe4), .RD_DATA(rd_data4),
        .MDIO_DONE(mdio_done4), .BUSY(busy4)
    );

    // Runs the accepting edge E0 plus edges E1..E65 on the P=0 instance and records what it saw.
    task automatic capture(input logic [15:0] reply, input logic keep_start, input logic [31:0] mid_data);
        logic prev_mdc;
        int   k;
        bits_seen = '0; oe_seen = '0; mdc_rises = 0; done_at = -1; done_cnt = 0;
        busy_at_done = 1'b1; rd_at_done = '0;
        @(posedge clk); #1;
        busy_e0 = busy;
        if (!keep_start) start = 1'b0;
        prev_mdc = mdc;
        for (int e = 1; e <= 65; e++) begin
            @(posedge clk); #1;
            if (mdc && !prev_mdc) mdc_rises++;
            prev_mdc = mdc;
            if (e % 2 == 0 && e <= 64) begin
                k = (e - 2) / 2;
                bits_seen[31-k] = mdio_out;
                oe_seen[31-k]   = mdio_oe;
                if (k >= 16) mdio_in = reply[31-k];
            end
            if (mdio_done) begin
                done_cnt++;
                if (done_at < 0) begin
                    done_at      = e;
                    busy_at_done = busy;
                    rd_at_done   = rd_data;
                end
            end
            if (e == 20 && keep_start) tdata = mid_data;
        end
        mdio_in = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #2;
        total++; if ({mdc, mdio_out, mdio_oe, mdio_done, busy} !== 5'b0) begin
            bad++; $display("FAIL reset_outputs got=%b want=00000", {mdc, mdio_out, mdio_oe, mdio_done, busy});
        end
        total++; if (rd_data !== 16'h0000) begin
            bad++; $display("FAIL reset_rd_data got=%h want=0000", rd_data);
        end
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (mdc !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL idle_after_reset mdc=%b busy=%b want 0 0", mdc, busy);
        end
    endtask

    task automatic test_write();
        tdata = 32'h5092_ABCD; start = 1'b1;
        capture(16'h0000, 1'b0, 32'h0);
        total++; if (busy_e0 !== 1'b1) begin
            bad++; $display("FAIL write_busy_e0 got=%b want=1", busy_e0);
        end
        total++; if (bits_seen !== 32'h5092_ABCD) begin
            bad++; $display("FAIL write_bits got=%h want=5092abcd", bits_seen);
        end
        total++; if (oe_seen !== 32'hFFFF_FFFF) begin
            bad++; $display("FAIL write_oe got=%h want=ffffffff", oe_seen);
        end
        total++; if (mdc_rises !== 32) begin
            bad++; $display("FAIL write_mdc_pulses got=%0d want=32", mdc_rises);
        end
        total++; if (done_at !== 65 || done_cnt !== 1) begin
            bad++; $display("FAIL write_done got_edge=%0d got_cnt=%0d want 65 1", done_at, done_cnt);
        end
        total++; if (busy_at_done !== 1'b0 || rd_at_done !== 16'h0000) begin
            bad++; $display("FAIL write_busy_rd got=%b %h want=0 0000", busy_at_done, rd_at_done);
        end
        @(posedge clk); #1;
        total++; if (mdio_done !== 1'b0 || mdc !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL write_after_done done=%b mdc=%b busy=%b want 0 0 0", mdio_done, mdc, busy);
        end
    endtask

    task automatic test_read();
        tdata = 32'h6092_0000; start = 1'b1;
        capture(16'hBEEF, 1'b0, 32'h0);
        total++; if (oe_seen !== 32'hFFFC_0000) begin
            bad++; $display("FAIL read_oe got=%h want=fffc0000", oe_seen);
        end
        total++; if (bits_seen !== 32'h6090_0000) begin
            bad++; $display("FAIL read_bits got=%h want=60900000", bits_seen);
        end
        total++; if (done_at !== 65 || rd_at_done !== 16'hBEEF || busy_at_done !== 1'b0) begin
            bad++; $display("FAIL read_done edge=%0d rd=%h busy=%b want 65 beef 0", done_at, rd_at_done, busy_at_done);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_op11();
        tdata = 32'h7092_1234; start = 1'b1;
        capture(16'h1234, 1'b0, 32'h0);
        total++; if (oe_seen !== 32'hFFFF_FFFF || bits_seen !== 32'h7092_1234) begin
            bad++; $display("FAIL op11_frame oe=%h bits=%h want ffffffff 70921234", oe_seen, bits_seen);
        end
        total++; if (rd_at_done !== 16'hBEEF || done_at !== 65) begin
            bad++; $display("FAIL op11_rd_hold rd=%h edge=%0d want beef 65", rd_at_done, done_at);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        tdata = 32'h5123_4567; start = 1'b1;
        capture(16'h0000, 1'b1, 32'h5FFF_0000);
        total++; if (bits_seen !== 32'h5123_4567 || done_cnt !== 1 || done_at !== 65) begin
            bad++; $display("FAIL b2b_first bits=%h done_cnt=%0d edge=%0d want 51234567 1 65", bits_seen, done_cnt, done_at);
        end
        capture(16'h0000, 1'b0, 32'h0);
        total++; if (busy_e0 !== 1'b1) begin
            bad++; $display("FAIL b2b_restart busy=%b want=1", busy_e0);
        end
        total++; if (bits_seen !== 32'h5FFF_0000 || done_at !== 65) begin
            bad++; $display("FAIL b2b_second bits=%h edge=%0d want 5fff0000 65", bits_seen, done_at);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        int act;
        tdata = 32'h5092_ABCD; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (41) @(posedge clk);
        #1;
        total++; if (mdio_oe !== 1'b1 || busy !== 1'b1) begin
            bad++; $display("FAIL mid_active oe=%b busy=%b want 1 1", mdio_oe, busy);
        end
        #2 reset = 1'b1;
        #1;
        total++; if ({mdc, mdio_out, mdio_oe, mdio_done, busy} !== 5'b0 || rd_data !== 16'h0000) begin
            bad++; $display("FAIL mid_reset outs=%b rd=%h want 00000 0000", {mdc, mdio_out, mdio_oe, mdio_done, busy}, rd_data);
        end
        @(posedge clk); @(posedge clk);
        #1 reset = 1'b0;
        act = 0;
        for (int e = 0; e < 12; e++) begin
            @(posedge clk); #1;
            if (mdc || busy || mdio_oe) act++;
        end
        total++; if (act !== 0) begin
            bad++; $display("FAIL post_reset_quiet active_cycles=%0d want=0", act);
        end
    endtask

    task automatic test_preamble();
        logic [35:0] b4, o4;
        int          d4_at, d4_cnt, n;
        b4 = '0; o4 = '0; d4_at = -1; d4_cnt = 0;
        tdata4 = 32'h5000_0001; start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        for (int e = 1; e <= 74; e++) begin
            @(posedge clk); #1;
            if (e % 2 == 0 && e <= 72) begin
                n = (e - 2) / 2;
                b4[35-n] = mdio_out4;
                o4[35-n] = mdio_oe4;
            end
            if (mdio_done4) begin
                d4_cnt++;
                if (d4_at < 0) d4_at = e;
            end
        end
        total++; if (b4 !== 36'hF_5000_0001) begin
            bad++; $display("FAIL pre_bits got=%h want=f50000001", b4);
        end
        total++; if (o4 !== 36'hF_FFFF_FFFF) begin
            bad++; $display("FAIL pre_oe got=%h want=fffffffff", o4);
        end
        total++; if (d4_at !== 73 || d4_cnt !== 1) begin
            bad++; $display("FAIL pre_done edge=%0d cnt=%0d want 73 1", d4_at, d4_cnt);
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0; start4 = 1'b0;
        tdata = '0; tdata4 = '0;
        mdio_in = 1'b0; mdio_in4 = 1'b0;
        test_reset();
        test_write();
        test_read();
        test_op11();
        test_back_to_back();
        test_reset_mid();
        test_preamble();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mdio_controller.md
Name: mdio_controller

Overview:
- Station-management (initiator) end of the MDIO link; the counterpart of the PHY-side peripheral.
- Accepts a 32-bit management frame from a host, generates MDC at CLK/2, and serializes the frame MSB first on MDIO_OUT/MDIO_OE.
- For read frames it releases the line at turnaround and shifts the 16-bit reply from MDIO_IN into RD_DATA.
- Signals completion with a one-cycle MDIO_DONE pulse.

Parameters:
- PREAMBLE_LEN, 0, number of '1' preamble bits driven before the frame (legal 0..32). Keep 0 when talking to the team's peripheral.

Ports:
- CLK  input  1  system clock; MDC is derived from it.
- RESET  input  1  asynchronous, active-high reset.
- MDIO_START  input  1  start request, sampled only in IDLE.
- T_DATA  input  32  frame to send: [31:30] ST, [29:28] OP, [27:23] PHYADR, [22:18] REGADR, [17:16] TA, [15:0] DATA.
- MDIO_IN  input  1  serial data from the peripheral; used during read data bits.
- MDC  output  1  management clock, CLK/2 while active, 0 when idle.
- MDIO_OUT  output  1  serial data to the peripheral.
- MDIO_OE  output  1  high while the controller drives the line.
- RD_DATA  output  16  last read result.
- MDIO_DONE  output  1  one-CLK pulse at end of frame.
- BUSY  output  1  high from start acceptance to MDIO_DONE.

Behaviour:
- Reset (async):
  - Outputs: MDC, MDIO_OUT, MDIO_OE, MDIO_DONE, BUSY = 0; RD_DATA = 0.
  - Internal: shift register and counters cleared; state = IDLE.
  - A reset mid-frame aborts the frame immediately; the frame is not resumed after reset.
- States: IDLE -> PREAMBLE (skipped if PREAMBLE_LEN=0) -> SHIFT -> DONE -> IDLE.
- IDLE:
  - At edge E0 with MDIO_START=1: latch T_DATA, BUSY=1.
  - Read frame iff T_DATA[29:28]==2'b10; every other OP code is handled as a write (line driven for all 32 bits).
  - ST/TA contents are transmitted as given; no validity checks.
- Bit timing (each bit = 2 CLK cycles, P = PREAMBLE_LEN):
  - Bit n (n=0 is the first preamble or frame bit) is driven on MDIO_OUT at edge E(1+2n) with MDC=0.
  - MDC=1 at E(2+2n); the peripheral samples on this rising MDC.
  - MDC returns to 0 at E(3+2n), when the next bit is driven.
  - Total bits = P+32.
- PREAMBLE: MDIO_OE=1, MDIO_OUT=1 for P bits.
- SHIFT, write frame: MDIO_OE=1 for all 32 frame bits; MDIO_OUT = T_DATA[31-k] for frame bit k.
- SHIFT, read frame:
  - MDIO_OE=1 for frame bits 0..13.
  - MDIO_OE=0 and MDIO_OUT=0 from the drive edge of frame bit 14 (TA) through the end of the frame.
  - MDIO_IN is sampled at the MDC-falling edge ending frame bits 16..31 and shifted in MSB first.
- DONE, at edge E(3+2(P+31)):
  - MDC=0, MDIO_OE=0, MDIO_OUT=0, MDIO_DONE=1 for one cycle, BUSY=0.
  - RD_DATA is loaded with the shifted value on reads only; on writes it holds its previous value.
  - Latency with P=0: MDIO_DONE at E65 after the accepting edge E0.
- Start handling:
  - MDIO_START while BUSY=1 is ignored; no queuing.
  - A start is accepted again on the first edge after MDIO_DONE (state IDLE), giving back-to-back frames one idle cycle apart.
- MDC never toggles in IDLE; no glitches. All outputs are registered.

Test Plan:
- Write: T_DATA=32'h5092_ABCD, P=0, pulse START -> 32 MDC pulses; MDIO_OE=1 throughout; bits observed on MDC rise = 0101_0000_1001_0010_1010_1011_1100_1101; MDIO_DONE single pulse at E65; RD_DATA unchanged.
- Read: T_DATA=32'h6092_0000, peripheral model drives 16'hBEEF on data bits -> MDIO_OE drops at frame bit 14; RD_DATA=16'hBEEF at MDIO_DONE; BUSY=0 the same edge.
- START held high during a frame plus a new T_DATA mid-frame -> the transmitted frame is unchanged; a second frame starts one cycle after MDIO_DONE using T_DATA sampled then.
- RESET asserted at frame bit 20 -> all outputs 0 asynchronously; after release, no MDC activity until a new START.
- PREAMBLE_LEN=4, write 32'h5000_0001 -> 4 ones with OE=1 precede ST; MDIO_DONE at E73.
- OP=2'b11 frame -> handled as a write: OE stays high for all 32 bits; RD_DATA not updated.
